// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: folds E0/F0 prefixes into one 32-bit key-event word.
// Latency: keyboard_data updates 4 clk cycles after the stop-bit falling edge at the pin.
// Backpressure: none; software polls the free-running event count, nothing is acknowledged.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   ps2_clk        raw PS/2 clock pin (asynchronous)
//   ps2_data       raw PS/2 data pin (asynchronous)
//   keyboard_data  {err_cnt[31:24], evt_cnt[23:16], 6'b0, release[9], extended[8], code[7:0]}
// Build option: define PS2_PARITY_CHECK_EN to reject frames whose data+parity
// bits do not have odd parity; otherwise only a low stop bit marks a bad frame.
module ps2_keyboard_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [31:0] keyboard_data
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // ---------------------------------------------------------------
    // Pin synchronisers; idle level of both PS/2 lines is high.
    // ---------------------------------------------------------------
    logic clk_s1, clk_s2, clk_d;
    logic dat_s1, dat_s2;
    logic fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_d  <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            clk_d  <= clk_s2;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    assign fall = clk_d & ~clk_s2;

    // ---------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          timeout_hit;
    logic          frame_done;
    logic          frame_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        frame_done = 1'b0;
        frame_bad  = 1'b0;
        // An edge in the same cycle wins over the timeout, so the two
        // error sources can never both fire at once.
        timeout_hit = (state_q != ST_IDLE) && !fall && (to_cnt_q == TOUT_LAST);

        if (timeout_hit) begin
            state_d = ST_IDLE;
        end else if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat_s2) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat_s2, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_d = dat_s2;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d    = ST_IDLE;
                    frame_done = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                    frame_bad  = ~dat_s2 | ~(^{shift_q, parity_q});
`else
                    frame_bad  = ~dat_s2;
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (fall || timeout_hit || state_q == ST_IDLE) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

`ifndef PS2_PARITY_CHECK_EN
    // Parity is captured for visibility but plays no part in validation here.
    logic unused_parity;
    assign unused_parity = parity_q;
`endif

    // ---------------------------------------------------------------
    // Frame result register: one cycle between stop sample and output.
    // ---------------------------------------------------------------
    logic       byte_vld_q;
    logic [7:0] byte_dat_q;
    logic       err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_vld_q <= 1'b0;
            byte_dat_q <= '0;
            err_q      <= 1'b0;
        end else begin
            byte_vld_q <= frame_done & ~frame_bad;
            byte_dat_q <= shift_q;
            err_q      <= timeout_hit | (frame_done & frame_bad);
        end
    end

    // ---------------------------------------------------------------
    // Byte decoder and counters
    // ---------------------------------------------------------------
    logic [7:0] code_q;
    logic       ext_q, brk_q;
    logic       ext_pend, brk_pend;
    logic [7:0] evt_cnt_q, err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            code_q    <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            evt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (err_q) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end else if (byte_vld_q) begin
            if (byte_dat_q == 8'hE0) begin
                ext_pend <= 1'b1;
            end else if (byte_dat_q == 8'hF0) begin
                brk_pend <= 1'b1;
            end else begin
                code_q    <= byte_dat_q;
                ext_q     <= ext_pend;
                brk_q     <= brk_pend;
                evt_cnt_q <= evt_cnt_q + 8'd1;   // wraps 255 -> 0
                ext_pend  <= 1'b0;
                brk_pend  <= 1'b0;
            end
        end
    end

    assign keyboard_data = {err_cnt_q, evt_cnt_q, 6'b0, brk_q, ext_q, code_q};

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboarded bench for ps2_keyboard_rx: stimulus pushes expected words,
// a monitor pops and compares whenever keyboard_data changes.
module tb_ps2_keyboard_rx;

    localparam int TO = 200;   // short timeout keeps the run small
    localparam int HP = 4;     // PS/2 half period in clk cycles (8x slower)

    typedef struct {
        logic [31:0] word;
        bit          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [31:0] keyboard_data;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_stop_cyc = 0;
    bit          mon_en = 1'b0;
    logic [31:0] prev_kd;
    logic [31:0] exp_last = 32'h0;
    exp_t        exp_q[$];

    ps2_keyboard_rx #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .keyboard_data(keyboard_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (mon_en && keyboard_data !== prev_kd) begin
            exp_t e;
            prev_kd = keyboard_data;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change: got %h, required no change", keyboard_data);
            end else begin
                e = exp_q.pop_front();
                if (keyboard_data !== e.word) begin
                    errors++;
                    $display("FAIL word: got %h, required %h", keyboard_data, e.word);
                end
                if (e.lat) begin
                    checks++;
                    if (cyc - last_stop_cyc != 4) begin
                        errors++;
                        $display("FAIL latency: got %0d cycles, required 4", cyc - last_stop_cyc);
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 80000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w, input bit lat);
        exp_t e;
        e.word = w;
        e.lat  = lat;
        exp_q.push_back(e);
        exp_last = w;
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit flip, input bit stop);
        return {stop, (~^b) ^ flip, b, 1'b0};
    endfunction

    // Drive bits lo..hi of an 11-bit frame, LSB first.
    task automatic send_bits(input logic [10:0] bits, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            ps2_data = bits[i];
            wait_cyc(HP);
            ps2_clk = 1'b0;
            if (i == 10) last_stop_cyc = cyc;
            wait_cyc(HP);
            ps2_clk = 1'b1;
        end
        wait_cyc(HP);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip, input bit stop);
        send_bits(frame_bits(b, flip, stop), 0, 10);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        if (exp_last != 32'h0) push(32'h0, 1'b0);
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(2);
    endtask

    initial begin
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(1);
        checks++;
        if (keyboard_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_value: got %h, required 00000000", keyboard_data);
        end
        prev_kd = keyboard_data;
        mon_en  = 1'b1;

        // Make, break, extended break, pending flags cleared
        push(32'h0001_001C, 1'b1); send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        push(32'h0002_021C, 1'b1); send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        push(32'h0003_0375, 1'b1); send_frame(8'h75, 1'b0, 1'b1);
        push(32'h0004_0075, 1'b1); send_frame(8'h75, 1'b0, 1'b1);

        // Event counter wraps 255 -> 0
        for (int i = 5; i <= 256; i++) begin
            logic [7:0] ev;
            ev = 8'(i);
            push({8'h00, ev, 16'h001C}, 1'b0);
            send_frame(8'h1C, 1'b0, 1'b1);
        end

        // Parity error
        do_reset();
`ifdef PS2_PARITY_CHECK_EN
        push(32'h0100_0000, 1'b1);
`else
        push(32'h0001_001C, 1'b1);
`endif
        send_frame(8'h1C, 1'b1, 1'b1);

        // Timeout recovery
        do_reset();
        push(32'h0100_0000, 1'b0);
        send_bits(frame_bits(8'h00, 1'b0, 1'b1), 0, 4);
        wait_cyc(TO + 10);
        push(32'h0101_0029, 1'b1);
        send_frame(8'h29, 1'b0, 1'b1);

        // Reset mid-frame: remaining bits of the aborted frame are all ones
        do_reset();
        send_bits(frame_bits(8'hF0, 1'b0, 1'b1), 0, 5);
        do_reset();
        send_bits(frame_bits(8'hF0, 1'b0, 1'b1), 6, 10);
        push(32'h0001_005A, 1'b1);
        send_frame(8'h5A, 1'b0, 1'b1);

        // Error counter saturates at 255 (bad stop bit)
        do_reset();
        for (int i = 1; i <= 256; i++) begin
            logic [7:0] er;
            er = 8'(i);
            if (i <= 255) push({er, 24'h0}, 1'b1);
            send_frame(8'h00, 1'b0, 1'b0);
        end
        push(32'hFF01_001C, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);

        wait_cyc(20);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations: got %0d left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
